// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment codes,
// the segment-vector type and the index-width helper.
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;

  // Active-high codes, bit0 = a .. bit6 = g, for hex digits 0..F.
  localparam seg7_t SEG_CODES [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((32'sd1 <<< w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex-nibble to active-high seven-segment decoder.
module seg7_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scanner with double-buffered display data so that
// every frame shows one consistent value.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRESC_PRE  = PW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};

  logic [PW-1:0]           presc_r;
  logic [IW-1:0]           idx_r;
  logic                    tick_r;
  logic [4*NUM_DIGITS-1:0] pend_val_r, act_val_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r, pend_en_r, act_en_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    dp_r;

  logic                    tc_s, wrap_s, pre_wrap_s, blank_s, zero_run_s, dp_s;
  logic [NUM_DIGITS-1:0]   upper_zero_s, an_s;
  logic [3:0]              nibble_s;
  seg7_t                   code_s, seg_s;

  assign tc_s       = (presc_r == PRESC_LAST);
  assign wrap_s     = tc_s && (idx_r == IDX_LAST);
  // One cycle ahead of the wrap, so the registered tick lines up with it.
  assign pre_wrap_s = (presc_r == PRESC_PRE) && (idx_r == IDX_LAST);

  // Prescaler, digit index and frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
      idx_r   <= '0;
      tick_r  <= 1'b0;
    end else begin
      tick_r <= pre_wrap_s;
      if (tc_s) begin
        presc_r <= '0;
        idx_r   <= wrap_s ? '0 : idx_r + 1'b1;
      end else begin
        presc_r <= presc_r + 1'b1;
      end
    end
  end

  // Pending capture on load; active update only at the frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_val_r <= '0;
      pend_dp_r  <= '0;
      pend_en_r  <= '0;
      act_val_r  <= '0;
      act_dp_r   <= '0;
      act_en_r   <= '0;
    end else begin
      if (load) begin
        pend_val_r <= value;
        pend_dp_r  <= dp_in;
        pend_en_r  <= digit_en;
      end
      if (wrap_s) begin
        act_val_r <= load ? value    : pend_val_r;
        act_dp_r  <= load ? dp_in    : pend_dp_r;
        act_en_r  <= load ? digit_en : pend_en_r;
      end
    end
  end

  // upper_zero_s[k]: every active nibble from the top down to k is zero.
  always_comb begin
    zero_run_s   = 1'b1;
    upper_zero_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run_s      = zero_run_s & (act_val_r[4*k +: 4] == 4'h0);
      upper_zero_s[k] = zero_run_s;
    end
  end

  assign nibble_s = act_val_r[{idx_r, 2'b00} +: 4];
  assign blank_s  = ~act_en_r[idx_r] |
                    (lz_blank & (idx_r != '0) & upper_zero_s[idx_r]);

  seg7_hex_lut u_lut (
    .nibble (nibble_s),
    .seg    (code_s)
  );

  // Active-high view of the current digit, forced dark when blanked.
  always_comb begin
    if (blank_s) begin
      an_s  = '0;
      seg_s = '0;
      dp_s  = 1'b0;
    end else begin
      an_s  = ONE_HOT << idx_r;
      seg_s = code_s;
      dp_s  = act_dp_r[idx_r];
    end
  end

  // Output registers; polarity applied only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r  <= AN_POL;
      seg_r <= SEG_POL;
      dp_r  <= ACTIVE_LOW;
    end else begin
      an_r  <= an_s ^ AN_POL;
      seg_r <= seg_s ^ SEG_POL;
      dp_r  <= dp_s ^ ACTIVE_LOW;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: two instances (active-low and active-high) driven together
// and compared every cycle against a cycle-count based display model.
module tb_seven_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset, load, lz;
  logic [15:0] value;
  logic [3:0]  dp_in, en;
  logic [3:0]  an_l, an_h;
  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h, tick_l, tick_h;

  int checks   = 0;
  int failures = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: cycles since reset release, plus pending/active data.
  int          mcyc;
  logic [15:0] p_v, a_v;
  logic [3:0]  p_dp, a_dp, p_en, a_en;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(en), .lz_blank(lz), .an(an_l), .seg(seg_l), .dp(dp_l), .frame_tick(tick_l)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(en), .lz_blank(lz), .an(an_h), .seg(seg_h), .dp(dp_h), .frame_tick(tick_h)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Active-high view {an, seg, dp} of digit k for the given display data.
  function automatic logic [11:0] disp_hi(input int k, input logic [15:0] v,
                                          input logic [3:0] dpv, input logic [3:0] e,
                                          input logic lzb);
    logic       blank;
    logic [3:0] onehot;
    logic [3:0] nib;
    blank = !e[k];
    if (lzb && k > 0 && (v >> (4 * k)) == 16'h0) blank = 1'b1;
    if (blank) return 12'h000;
    onehot = 4'b0001 << k;
    nib    = 4'(v >> (4 * k));
    return {onehot, hex_tab[nib], dpv[k]};
  endfunction

  task automatic step();
    logic [11:0] e;
    logic [3:0]  ea_h, ea_l;
    logic [6:0]  es_h, es_l;
    logic        ed_h, ed_l, wrap, etick;
    e    = disp_hi((mcyc / DIV) % N, a_v, a_dp, a_en, lz);
    wrap = (mcyc % FRAME) == FRAME - 1;
    if (load) begin
      p_v = value; p_dp = dp_in; p_en = en;
      if (wrap) begin a_v = value; a_dp = dp_in; a_en = en; end
    end else if (wrap) begin
      a_v = p_v; a_dp = p_dp; a_en = p_en;
    end
    mcyc++;
    etick = (mcyc % FRAME) == FRAME - 1;
    ea_h = e[11:8]; es_h = e[7:1]; ed_h = e[0];
    ea_l = ~ea_h;   es_l = ~es_h;  ed_l = ~ed_h;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("an_low", an_l, ea_l);
    check("seg_low", seg_l, es_l);
    check("dp_low", dp_l, ed_l);
    check("tick_low", tick_l, etick);
    check("an_high", an_h, ea_h);
    check("seg_high", seg_h, es_h);
    check("dp_high", dp_h, ed_h);
    check("tick_high", tick_h, etick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int ph);
    step();
    while ((mcyc % FRAME) != ph) step();
  endtask

  task automatic present(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    value = v; dp_in = d; en = e; load = 1'b1;
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    load  = 1'b0;
    #1;
    check("rst_an_low", an_l, 4'hF);
    check("rst_seg_low", seg_l, 7'h7F);
    check("rst_dp_low", dp_l, 1'b1);
    check("rst_tick_low", tick_l, 1'b0);
    check("rst_an_high", an_h, 4'h0);
    check("rst_seg_high", seg_h, 7'h00);
    check("rst_tick_high", tick_h, 1'b0);
    mcyc = 0;
    p_v = '0; p_dp = '0; p_en = '0;
    a_v = '0; a_dp = '0; a_en = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] s031 [4] = '{7'h71, 7'h77, 7'h5B, 7'h06};
    logic [3:0] an032 [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [6:0] s032 [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    logic [6:0] sx;
    logic [3:0] ax;
    reset = 1'b0; load = 1'b0; lz = 1'b0;
    value = '0; dp_in = '0; en = '0;
    apply_reset();

    // Basic display of 12AF with the decimal point on digit 2.
    present(16'h12AF, 4'b0100, 4'hF);
    for (int d = 0; d < N; d++) begin
      while (mcyc < FRAME + 1 + DIV * d) step();
      sx = ~s031[d];
      ax = ~(4'b0001 << d);
      check("r031_seg", seg_l, sx);
      check("r031_an", an_l, ax);
      check("r031_dp", dp_l, (d == 2) ? 1'b0 : 1'b1);
    end

    // Leading-zero suppression, then with suppression off.
    present(16'h0050, 4'b0000, 4'hF);
    lz = 1'b1;
    run(2 * FRAME);
    for (int d = 0; d < N; d++) begin
      run_to_phase(DIV * d + 2);
      sx = ~s032[d];
      check("r032_an", an_l, an032[d]);
      check("r032_seg", seg_l, sx);
    end
    lz = 1'b0;
    run(FRAME);
    run_to_phase(3 * DIV + 2);
    sx = ~7'h3F;
    check("r032_nolz_seg3", seg_l, sx);
    check("r032_nolz_an3", an_l, 4'h7);

    // Mid-frame reload must not tear the frame.
    present(16'h1111, 4'h0, 4'hF);
    run_to_phase(1);
    run_to_phase(6);
    present(16'h2222, 4'h0, 4'hF);
    run_to_phase(2 * DIV + 2);
    sx = ~7'h06;
    check("r033_old_frame", seg_l, sx);
    run_to_phase(2);
    sx = ~7'h5B;
    check("r033_new_frame", seg_l, sx);

    // Load coincident with the wrap goes straight to the active registers.
    run_to_phase(FRAME - 1);
    present(16'h3C5A, 4'h0, 4'hF);
    run(2);
    sx = ~7'h77;
    check("r034_digit0", seg_l, sx);

    // Reset during the digit-2 slot, then a clean restart.
    run_to_phase(2 * DIV + 1);
    apply_reset();
    present(16'h4321, 4'h0, 4'hF);
    run(3 * FRAME);

    // Active-high rotation with all segments lit.
    present(16'h8888, 4'h0, 4'hF);
    run(2 * FRAME);
    for (int d = 0; d < N; d++) begin
      run_to_phase(DIV * d + 2);
      ax = 4'b0001 << d;
      check("r036_an_high", an_h, ax);
      check("r036_seg_high", seg_h, 7'h7F);
    end

    // Randomized loads, enables, decimal points and leading-zero toggling.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        present(16'($urandom) >> (4 * $urandom_range(0, 4)),
                4'($urandom), 4'($urandom | (($urandom_range(0, 2) == 0) ? 0 : 32'hF)));
      end
      if ($urandom_range(0, 39) == 0) lz = ~lz;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
